// File: rtl/bcm_scan_scheduler_if.sv
// rtl/bcm_scan_scheduler_if.sv - scan scheduler control/status bundle
interface bcm_scan_scheduler_if #(
  parameter int ROWS = 16,
  parameter int BITS = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

  logic            enable;
  logic [7:0]      brightness;
  logic            shift_done;
  logic            shift_start;
  logic            latch_enable;
  logic            output_enable_n;
  logic [ROWS-1:0] row_select_n;
  logic [RW-1:0]   row;
  logic [BW-1:0]   bitplane;
  logic            frame_start;
  logic            busy;
  logic            error;

  modport master (
    input  enable, brightness, shift_done,
    output shift_start, latch_enable, output_enable_n, row_select_n,
    output row, bitplane, frame_start, busy, error
  );

  modport slave (
    output enable, brightness, shift_done,
    input  shift_start, latch_enable, output_enable_n, row_select_n,
    input  row, bitplane, frame_start, busy, error
  );
endinterface

// File: rtl/bcm_scan_scheduler.sv
// rtl/bcm_scan_scheduler.sv - BCM row/bit-plane scan sequencer for the LED cube
module bcm_scan_scheduler #(
  parameter int ROWS          = 16,
  parameter int BITS          = 8,
  parameter int BASE_TICKS    = 4,
  parameter int BLANK_TICKS   = 8,
  parameter int SHIFT_TIMEOUT = 1024
) (
  input logic                   clk,
  input logic                   reset,
  bcm_scan_scheduler_if.master  bus
);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW      = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int MAXSLOT = BASE_TICKS << (BITS - 1);
  localparam int M1      = (SHIFT_TIMEOUT > MAXSLOT) ? SHIFT_TIMEOUT : MAXSLOT;
  localparam int MAXC    = (M1 > BLANK_TICKS) ? M1 : BLANK_TICKS;
  localparam int CW      = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_row;
  logic [BW-1:0]   r_bitplane;
  logic [7:0]      r_bri;
  logic            r_shift_start;
  logic            r_latch;
  logic            r_oe_n;
  logic [ROWS-1:0] r_row_sel_n;
  logic            r_frame_start;
  logic            r_busy;
  logic            r_error;

  logic [31:0]     w_slot;
  logic [31:0]     w_on;
  logic            w_last_row;
  logic            w_last_plane;

  assign w_slot       = 32'(BASE_TICKS) << r_bitplane;
  assign w_on         = (w_slot * (32'(r_bri) + 32'd1)) >> 8;
  assign w_last_row   = (r_row == RW'(ROWS - 1));
  assign w_last_plane = (r_bitplane == BW'(BITS - 1));

  function automatic logic [ROWS-1:0] sel_n(input logic [RW-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  // frame_start is issued one cycle ahead of the first shift_start of a frame:
  // from IDLE it is its own cycle, at a row wrap it lands on the last blank cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_row         <= '0;
      r_bitplane    <= '0;
      r_bri         <= '0;
      r_shift_start <= 1'b0;
      r_latch       <= 1'b0;
      r_oe_n        <= 1'b1;
      r_row_sel_n   <= '1;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_shift_start <= 1'b0;
      r_latch       <= 1'b0;
      r_frame_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_oe_n      <= 1'b1;
          r_row_sel_n <= '1;
          if (r_frame_start) begin
            r_state       <= S_SHIFT;
            r_cnt         <= '0;
            r_row         <= '0;
            r_bitplane    <= '0;
            r_shift_start <= 1'b1;
            r_row_sel_n   <= sel_n('0);
          end else if (bus.enable) begin
            r_frame_start <= 1'b1;
            r_bri         <= bus.brightness;
            r_busy        <= 1'b1;
          end
        end
        S_SHIFT: begin
          // shift_done in the entry cycle (r_cnt == 0) belongs to a stale request
          if ((r_cnt != '0 && bus.shift_done) || r_cnt == CW'(SHIFT_TIMEOUT)) begin
            r_state <= S_LATCH;
            r_latch <= 1'b1;
          end else begin
            if (r_cnt == CW'(SHIFT_TIMEOUT - 1)) r_error <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          r_state <= S_DISPLAY;
          r_cnt   <= '0;
          r_oe_n  <= (w_on == 32'd0);
        end
        S_DISPLAY: begin
          if (32'(r_cnt) == w_slot - 32'd1) begin
            r_oe_n <= 1'b1;
            r_cnt  <= '0;
            if (!w_last_plane) begin
              r_state       <= S_SHIFT;
              r_bitplane    <= r_bitplane + 1'b1;
              r_shift_start <= 1'b1;
            end else begin
              r_state     <= S_BLANK;
              r_row_sel_n <= '1;
            end
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_oe_n <= !(32'(r_cnt) + 32'd1 < w_on);
          end
        end
        S_BLANK: begin
          if (r_cnt == CW'(BLANK_TICKS - 1)) begin
            r_cnt      <= '0;
            r_bitplane <= '0;
            if (w_last_row) begin
              r_row <= '0;
              if (r_frame_start) begin
                r_state       <= S_SHIFT;
                r_shift_start <= 1'b1;
                r_row_sel_n   <= sel_n('0);
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_row         <= r_row + 1'b1;
              r_state       <= S_SHIFT;
              r_shift_start <= 1'b1;
              r_row_sel_n   <= sel_n(r_row + 1'b1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_row && r_cnt == CW'(BLANK_TICKS - 2) && bus.enable) begin
              r_frame_start <= 1'b1;
              r_bri         <= bus.brightness;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.shift_start     = r_shift_start;
  assign bus.latch_enable    = r_latch;
  assign bus.output_enable_n = r_oe_n;
  assign bus.row_select_n    = r_row_sel_n;
  assign bus.row             = r_row;
  assign bus.bitplane        = r_bitplane;
  assign bus.frame_start     = r_frame_start;
  assign bus.busy            = r_busy;
  assign bus.error           = r_error;
endmodule

// File: doc/bcm_scan_scheduler.md
Name: bcm_scan_scheduler

Overview:
- Sequences the LED cube scan datapath using binary code modulation (BCM).
- For each row, and for each bit-plane within that row: requests a shift of the plane's serial data, latches it, then enables the drivers for a time weighted by the plane's bit position.
- Owns the row_select_n, latch_enable and output_enable_n timing.
- Sits between the serial shifter, which reports shift completion, and the board driver outputs.

Parameters:
ROWS, 16, number of scanned rows (one-hot active-low select)
BITS, 8, bit-planes per row (colour depth)
BASE_TICKS, 4, display-slot length in clk cycles for bit-plane 0
BLANK_TICKS, 8, all-off dead time between rows, in clk cycles
SHIFT_TIMEOUT, 1024, maximum cycles to wait for shift_done

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
enable  in  1  run request
brightness  in  8  global dimming; sampled only at frame start
shift_done  in  1  single-cycle pulse from shifter: current plane's data is shifted in
shift_start  out  1  single-cycle pulse: shifter loads and shifts plane `bitplane` of row `row`
latch_enable  out  1  single-cycle latch strobe to the drivers
output_enable_n  out  1  driver enable, active low
row_select_n  out  ROWS  active-low one-hot row drive
row  out  clog2(ROWS)  current row index
bitplane  out  clog2(BITS)  current bit-plane index
frame_start  out  1  single-cycle pulse at the start of each frame
busy  out  1  high in every state except IDLE
error  out  1  sticky flag: a shift timeout occurred; cleared only by reset

Behaviour:
- Reset values (asserted asynchronously, immediately, from any state):
  - shift_start=0, latch_enable=0, frame_start=0, busy=0, error=0
  - output_enable_n=1, row_select_n=all ones
  - row=0, bitplane=0, state=IDLE, all counters cleared
- States: IDLE, SHIFT, LATCH, DISPLAY, BLANK.
- IDLE:
  - Outputs: oe_n=1, row_select_n all ones.
  - If enable=1, on the next edge: capture brightness into bri_q, pulse frame_start, and enter SHIFT with row=0, bitplane=0.
- SHIFT:
  - shift_start=1 in the entry cycle only.
  - shift_done is sampled from the cycle after entry onward; a shift_done in the entry cycle is ignored.
  - On shift_done -> LATCH.
  - The wait counter counts cycles spent in SHIFT. When it reaches SHIFT_TIMEOUT: set error=1 and go to LATCH anyway; the frame continues.
  - oe_n=1 throughout.
- LATCH:
  - latch_enable=1 for exactly one cycle, then DISPLAY.
  - oe_n=1.
- DISPLAY:
  - slot = BASE_TICKS << bitplane; slot counter runs 0..slot-1.
  - on_time = (slot * (bri_q + 1)) >> 8, computed at full width with no truncation before the shift.
  - oe_n=0 exactly while count < on_time, so on_time=0 means the drivers are never enabled in that slot.
  - At count == slot-1:
    - if bitplane < BITS-1: bitplane+1, go to SHIFT;
    - otherwise go to BLANK.
- BLANK:
  - Outputs: oe_n=1, row_select_n all ones, for BLANK_TICKS cycles.
  - Then row advances and bitplane resets to 0.
  - Row wrap: row=ROWS-1 wraps to 0. On wrap, this is a frame boundary:
    - if enable=1: pulse frame_start, recapture bri_q, go to SHIFT;
    - otherwise go to IDLE.
  - Without wrap: go to SHIFT regardless of enable. A mid-frame enable drop therefore completes the frame.
- row_select_n:
  - SHIFT, LATCH and DISPLAY: ~(1 << row).
  - IDLE and BLANK: all ones.
- All outputs are registered.
- The first shift_start follows the enable edge by one cycle.
- oe_n and latch_enable are never both active in the same cycle.
- brightness changes mid-frame have no effect until the next frame_start.

Test Plan:
- Common setup: ROWS=4, BITS=3, BASE_TICKS=2, BLANK_TICKS=3, SHIFT_TIMEOUT=16. A shifter model returns shift_done 5 cycles after shift_start.
- brightness=255, enable held -> per row, oe_n low runs of exactly 2, 4 and 8 cycles, each preceded by one latch_enable pulse; 3-cycle all-ones row_select_n gap between rows; row sequence 0,1,2,3,0; frame_start once per 4 rows.
- brightness=127 -> oe_n low runs of 1, 2 and 4 cycles with slot lengths unchanged. brightness=0 -> oe_n never low, while sequencing, latch_enable and frame_start timing are identical to the 255 case.
- Shifter model never responds -> error rises after 16 SHIFT cycles; latch_enable follows on the next cycle; the scan continues through all rows; error stays high until reset.
- Drop enable during row 1 -> rows 2 and 3 complete; IDLE entered after row 3's blank; busy=0, oe_n=1, row_select_n=4'b1111; no further shift_start.
- Assert reset mid-DISPLAY while oe_n=0 -> oe_n=1, row_select_n=all ones, row=0, error=0 in the same cycle, without waiting for a clk edge. On release with enable=1: frame_start, then shift_start on the following cycle.
- Pulse shift_done coincident with shift_start, then not again -> that pulse is ignored and the FSM stays in SHIFT; a later shift_done advances it to LATCH.
